// File: rtl/vr_pkg.sv
// Shared helpers for the valid/ready width converters.
// Holds the count width, output width and lane offset functions.
package vr_pkg;

    // Counter width; a one-lane index still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int out_width(input int in_w, input int ratio);
        return in_w * ratio;
    endfunction

    function automatic int lane_lo(input int lane, input int in_w);
        return lane * in_w;
    endfunction

endpackage

// File: rtl/vr_width_packer.sv
// Narrow-to-wide valid/ready packer, little-endian lanes, registered output.
// Define VR_PACK_LAST_EN to add m_last/s_keep/s_last partial-word flush.
module vr_width_packer
    import vr_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_valid,
    output logic                         m_ready,
    input  logic [IN_WIDTH-1:0]          m_data,
`ifdef VR_PACK_LAST_EN
    input  logic                         m_last,
    output logic [RATIO-1:0]             s_keep,
    output logic                         s_last,
`endif
    output logic                         s_valid,
    input  logic                         s_ready,
    output logic [IN_WIDTH*RATIO-1:0]    s_data
);

    localparam int OUT_WIDTH = out_width(IN_WIDTH, RATIO);
    localparam int ACC_W     = IN_WIDTH * (RATIO - 1);
    localparam int CW        = cnt_width(RATIO);

    logic [CW-1:0]        cnt;
    logic [ACC_W-1:0]     acc;
    logic [OUT_WIDTH-1:0] word;
    logic                 accept;
    logic                 at_end;
    logic                 last_in;
    logic                 done;

`ifdef VR_PACK_LAST_EN
    logic [RATIO-1:0]     keep;
    assign last_in = m_last;
`else
    assign last_in = 1'b0;
`endif

    assign m_ready = ~s_valid | s_ready;
    assign accept  = m_valid & m_ready;
    assign at_end  = (cnt == CW'(RATIO - 1));
    assign done    = accept & (at_end | last_in);

    // acc lanes at or above cnt are always zero, so the merged
    // word already has zeros above the incoming lane.
    always_comb begin
        word = OUT_WIDTH'(acc);
        word[lane_lo(int'(cnt), IN_WIDTH) +: IN_WIDTH] = m_data;
    end

`ifdef VR_PACK_LAST_EN
    always_comb begin
        keep = '0;
        for (int j = 0; j < RATIO; j++) begin
            keep[j] = (j <= int'(cnt));
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (done) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            cnt <= cnt + CW'(1);
            acc <= word[ACC_W-1:0];
        end
    end

    // A completion beat overrides the drain, so back-to-back words
    // never produce a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid <= 1'b0;
            s_data  <= '0;
`ifdef VR_PACK_LAST_EN
            s_keep  <= '0;
            s_last  <= 1'b0;
`endif
        end else if (done) begin
            s_valid <= 1'b1;
            s_data  <= word;
`ifdef VR_PACK_LAST_EN
            s_keep  <= keep;
            s_last  <= last_in;
`endif
        end else if (s_ready) begin
            s_valid <= 1'b0;
        end
    end

endmodule
